sys_sum_acc: RTL and testbench
==============================

Name: sys_sum_acc

Overview:
Accumulates DepthIn consecutive rows of NumOfNerves signed partial sums into per-nerve accumulators, then serialises the NumOfNerves totals one per cycle. Successor to the single-buffer systolic summer. Adds:
- separate input, accumulator and output widths
- saturating arithmetic with a sticky overflow flag
- optional shift and ReLU post-processing
- ready/valid backpressure on both sides
- double buffering, so accumulation of group N+1 overlaps draining of group N

Sits between systolic PE columns and the next layer's serial input.

Parameters:
InBits, 8, signed width of each in_data element
AccBits, 16, signed accumulator width (must be >= InBits)
OutBits, 8, signed width of out_data
NumOfNerves, 4, elements per row / outputs per group
DepthIn, 2, rows summed per group (>= 1)
OutShift, 0, arithmetic right shift applied before output saturation
ReluEn, 0, 1 = negative results are output as 0

Ports:
clk  in  1  single clock, rising edge
res_n  in  1  asynchronous active-low reset
in_valid  in  1  row present on in_data
in_start  in  1  qualifies the first row of a group
in_ready  out  1  row accepted when in_valid && in_ready
in_data  in  NumOfNerves x InBits  packed signed row; element i at [i]
out_ready  in  1  consumer accepts out_data when out_valid && out_ready
out_valid  out  1  out_data valid
out_start  out  1  first element of a group (nerve NumOfNerves-1)
out_last  out  1  last element of a group (nerve 0)
out_data  out  OutBits  post-processed total
overflow  out  1  sticky: any accumulator or output saturation

Behaviour:
- Reset (async assert, sync release): both banks and all counters cleared; acc side in ACC with row_cnt=0; drain side IDLE. Outputs: out_valid=0, out_start=0, out_last=0, out_data=0, overflow=0, in_ready=0 while res_n low, 1 on the first cycle after release. Reset mid-group or mid-drain discards all data.
- Accumulate side, states ACC and FULL. in_ready = (state==ACC). Only handshaked rows count.
  - Handshake with in_start=1: bank loaded with the sign-extended row, row_cnt=1. If row_cnt was nonzero, the partial group is discarded (resync).
  - Handshake with in_start=0 and row_cnt=0: row accepted and dropped.
  - Handshake with in_start=0 and row_cnt>0: each element is sign-extended to AccBits and added with saturation to [-2^(AccBits-1), 2^(AccBits-1)-1]. Saturation sets overflow. row_cnt increments.
  - When the handshaked row makes row_cnt==DepthIn, the group is complete. This includes DepthIn=1 with in_start.
- Handoff:
  - If the group completes while the drain side is IDLE, or on the drain's last-element handshake in the same cycle, the completed totals are copied into the drain bank at that edge. Acc returns to ACC with row_cnt=0 and there is no bubble.
  - Otherwise acc enters FULL, holding the totals. It transfers on the cycle the drain is IDLE or completes its last handshake, then returns to ACC.
- Drain side, states IDLE and DRAIN; idx counts NumOfNerves-1 down to 0.
  - out_valid=1 in DRAIN; outputs are registered.
  - First out_valid appears the cycle after the completing row's handshake, when there is no FULL wait.
  - out_data/out_start/out_last hold stable while out_valid && !out_ready.
  - idx decrements on each handshake. The handshake at idx 0 returns the drain to IDLE, or reloads it if a handoff occurs in the same cycle.
- Output arithmetic per element: v = total >>> OutShift; if ReluEn and v<0 then v=0; saturate v to OutBits signed. Output saturation sets overflow.
- Simultaneous in_start and group completion, with DepthIn=1, is treated as a complete group.
- Throughput: one row per cycle sustained when DepthIn >= NumOfNerves and out_ready=1. Otherwise in_ready drops while FULL.

Test Plan:
- Defaults. Rows [1,2,3,4] (start) then [10,20,30,40] -> out_data 44,33,22,11 on four consecutive cycles. out_start with 44, out_last with 11; overflow=0.
- Rows [100,100,100,100] x2 -> each total 200 saturates to 127, four outputs of 127, overflow=1 and stays 1 until res_n low.
- ReluEn=1, OutShift=1. Rows [-5,6,-7,8] and [-5,6,-7,8] -> totals -10,12,-14,16 -> outputs 8,0,6,0.
- out_ready=0 held; send three full groups back-to-back -> group 1 in drain, group 2 FULL, in_ready=0 after group 2's second row. Release out_ready -> 12 outputs in group order; no rows lost.
- in_start reasserted after one row of a group -> the partial row is discarded. Output equals the sum of the new start row plus its following row only.
- Assert res_n low mid-drain (after 2 outputs) -> out_valid=0 immediately (async). After release, in_ready=1 and no stale outputs appear.

Source files
------------

// File: rtl/sys_sum_acc_if.sv
// Row-in / serial-out bus of the systolic summing accumulator.
// The master drives rows and out_ready; the slave (the accumulator) answers.
interface sys_sum_acc_if #(
   parameter int InBits      = 8,
   parameter int OutBits     = 8,
   parameter int NumOfNerves = 4
);
   logic                                in_valid;
   logic                                in_start;
   logic                                in_ready;
   logic [NumOfNerves-1:0][InBits-1:0]  in_data;
   logic                                out_ready;
   logic                                out_valid;
   logic                                out_start;
   logic                                out_last;
   logic [OutBits-1:0]                  out_data;
   logic                                overflow;

   modport master (
      output in_valid, in_start, in_data, out_ready,
      input  in_ready, out_valid, out_start, out_last, out_data, overflow
   );

   modport slave (
      input  in_valid, in_start, in_data, out_ready,
      output in_ready, out_valid, out_start, out_last, out_data, overflow
   );
endinterface

// File: rtl/sys_sum_acc.sv
// Double-buffered per-nerve accumulator: sums DepthIn rows, then serialises
// the NumOfNerves totals (highest nerve first) while the next group accumulates.
module sys_sum_acc_lane #(
   parameter int InBits  = 8,
   parameter int AccBits = 16
) (
   input  logic               clk,
   input  logic               res_n,
   input  logic [InBits-1:0]  i_in,
   input  logic               i_start,
   input  logic               i_we,
   input  logic               i_xfer,
   input  logic               i_from_acc,
   output logic [AccBits-1:0] o_src,
   output logic [AccBits-1:0] o_drn,
   output logic               o_sat
);
   localparam logic signed [AccBits-1:0] AMAX = {1'b0, {(AccBits-1){1'b1}}};
   localparam logic signed [AccBits-1:0] AMIN = ~AMAX;

   logic signed [AccBits-1:0] r_acc, r_drn, w_ext, w_add, w_next;
   logic signed [AccBits:0]   w_sum;
   logic                      w_ovf;

   assign w_ext  = AccBits'($signed(i_in));
   assign w_sum  = {r_acc[AccBits-1], r_acc} + {w_ext[AccBits-1], w_ext};
   assign w_ovf  = w_sum[AccBits] != w_sum[AccBits-1];
   assign w_add  = w_ovf ? (w_sum[AccBits] ? AMIN : AMAX) : w_sum[AccBits-1:0];
   assign w_next = i_start ? w_ext : w_add;
   // A group waiting in FULL hands over the held bank; otherwise the row being completed.
   assign o_src  = i_from_acc ? r_acc : w_next;
   assign o_drn  = r_drn;
   assign o_sat  = i_we && !i_start && w_ovf;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_acc <= '0;
         r_drn <= '0;
      end else begin
         if (i_we)   r_acc <= w_next;
         if (i_xfer) r_drn <= o_src;
      end
   end
endmodule

module sys_sum_acc #(
   parameter int InBits      = 8,
   parameter int AccBits     = 16,
   parameter int OutBits     = 8,
   parameter int NumOfNerves = 4,
   parameter int DepthIn     = 2,
   parameter int OutShift    = 0,
   parameter int ReluEn      = 0
) (
   input logic           clk,
   input logic           res_n,
   sys_sum_acc_if.slave  bus
);
   localparam int CW = $clog2(DepthIn + 1);
   localparam int IW = (NumOfNerves > 1) ? $clog2(NumOfNerves) : 1;
   localparam logic signed [AccBits-1:0] OMAX = {{(AccBits-OutBits+1){1'b0}}, {(OutBits-1){1'b1}}};
   localparam logic signed [AccBits-1:0] OMIN = ~OMAX;

   typedef enum logic {ACC, FULL}   acc_st_t;
   typedef enum logic {IDLE, DRAIN} drn_st_t;

   acc_st_t r_acc_st, w_acc_nx;
   drn_st_t r_drn_st, w_drn_nx;
   logic [CW-1:0] r_row_cnt, w_row_nx;
   logic [IW-1:0] r_idx, w_idx_nx;
   logic          r_live, r_ovf, r_start, r_last;
   logic [OutBits-1:0] r_out_data;

   logic w_hs_in, w_we, w_done, w_out_hs, w_last_hs, w_drn_free, w_xfer, w_load;
   logic [NumOfNerves-1:0][AccBits-1:0] w_src, w_drn;
   logic [NumOfNerves-1:0]              w_lane_sat;
   logic signed [AccBits-1:0]           w_sel, w_shv, w_v;
   logic                                w_post_sat;

   assign bus.in_ready  = r_live && (r_acc_st == ACC);
   assign bus.out_valid = (r_drn_st == DRAIN);
   assign bus.out_data  = r_out_data;
   assign bus.out_start = r_start;
   assign bus.out_last  = r_last;
   assign bus.overflow  = r_ovf;

   assign w_hs_in    = bus.in_valid && bus.in_ready;
   // Non-start rows arriving before any start row are swallowed without effect.
   assign w_we       = w_hs_in && (bus.in_start || (r_row_cnt != '0));
   assign w_done     = w_hs_in && (bus.in_start ? (DepthIn == 1)
                                   : ((r_row_cnt != '0) && (r_row_cnt == CW'(DepthIn - 1))));
   assign w_out_hs   = (r_drn_st == DRAIN) && bus.out_ready;
   assign w_last_hs  = w_out_hs && (r_idx == '0);
   assign w_drn_free = (r_drn_st == IDLE) || w_last_hs;
   assign w_xfer     = w_drn_free && ((r_acc_st == FULL) || w_done);
   assign w_load     = w_xfer || (w_out_hs && !w_last_hs);

   for (genvar g = 0; g < NumOfNerves; g++) begin : g_lane
      sys_sum_acc_lane #(.InBits(InBits), .AccBits(AccBits)) u_lane (
         .clk        (clk),
         .res_n      (res_n),
         .i_in       (bus.in_data[g]),
         .i_start    (bus.in_start),
         .i_we       (w_we),
         .i_xfer     (w_xfer),
         .i_from_acc (r_acc_st == FULL),
         .o_src      (w_src[g]),
         .o_drn      (w_drn[g]),
         .o_sat      (w_lane_sat[g])
      );
   end

   always_comb begin
      w_acc_nx = r_acc_st;
      w_row_nx = r_row_cnt;
      case (r_acc_st)
         ACC: if (w_hs_in) begin
            if (bus.in_start)           w_row_nx = CW'(1);
            else if (r_row_cnt != '0)   w_row_nx = r_row_cnt + CW'(1);
            if (w_done) begin
               w_row_nx = '0;
               if (!w_xfer) w_acc_nx = FULL;
            end
         end
         FULL: if (w_xfer) w_acc_nx = ACC;
         default: w_acc_nx = ACC;
      endcase
   end

   always_comb begin
      w_drn_nx = r_drn_st;
      w_idx_nx = r_idx;
      if (w_xfer) begin
         w_drn_nx = DRAIN;
         w_idx_nx = IW'(NumOfNerves - 1);
      end else if (w_last_hs) begin
         w_drn_nx = IDLE;
      end else if (w_out_hs) begin
         w_idx_nx = r_idx - IW'(1);
      end
   end

   // Element that becomes the next registered output: shift, ReLU, saturate.
   always_comb begin
      w_sel      = w_xfer ? w_src[NumOfNerves-1] : w_drn[w_idx_nx];
      w_shv      = w_sel >>> OutShift;
      w_v        = w_shv;
      w_post_sat = 1'b0;
      if ((ReluEn != 0) && (w_shv < 0)) w_v = '0;
      if (w_v > OMAX) begin
         w_v        = OMAX;
         w_post_sat = 1'b1;
      end else if (w_v < OMIN) begin
         w_v        = OMIN;
         w_post_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_acc_st   <= ACC;
         r_drn_st   <= IDLE;
         r_row_cnt  <= '0;
         r_idx      <= '0;
         r_live     <= 1'b0;
         r_ovf      <= 1'b0;
         r_start    <= 1'b0;
         r_last     <= 1'b0;
         r_out_data <= '0;
      end else begin
         r_acc_st  <= w_acc_nx;
         r_drn_st  <= w_drn_nx;
         r_row_cnt <= w_row_nx;
         r_idx     <= w_idx_nx;
         r_live    <= 1'b1;
         r_ovf     <= r_ovf || (|w_lane_sat) || (w_load && w_post_sat);
         if (w_load) begin
            r_out_data <= w_v[OutBits-1:0];
            r_start    <= (w_idx_nx == IW'(NumOfNerves - 1));
            r_last     <= (w_idx_nx == '0);
         end else if (w_last_hs) begin
            r_start <= 1'b0;
            r_last  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sys_sum_acc.sv
// Bench for sys_sum_acc: default instance plus a shift/ReLU instance, with
// expected totals queued from a behavioural model as rows are driven.
module tb_sys_sum_acc;
   localparam int N = 4;
   localparam int D = 2;

   logic clk = 1'b0;
   logic res_n = 1'b0;
   always #5 clk = ~clk;

   sys_sum_acc_if #(.InBits(8), .OutBits(8), .NumOfNerves(N)) if0 ();
   sys_sum_acc_if #(.InBits(8), .OutBits(8), .NumOfNerves(N)) if1 ();

   sys_sum_acc #(.DepthIn(D)) dut0 (.clk(clk), .res_n(res_n), .bus(if0));
   sys_sum_acc #(.DepthIn(D), .OutShift(1), .ReluEn(1)) dut1 (.clk(clk), .res_n(res_n), .bus(if1));

   typedef struct {int d; bit s; bit l;} exp_t;
   exp_t q0[$], q1[$];
   exp_t e0, e1;
   int checks = 0;
   int errors = 0;
   int rows[D][N];
   int one[N];

   always @(negedge clk) begin
      if (res_n && if0.out_valid && if0.out_ready) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL out0_unexpected got=%0d", $signed(if0.out_data));
         end else begin
            e0 = q0.pop_front();
            if ($signed(if0.out_data) !== e0.d || if0.out_start !== e0.s || if0.out_last !== e0.l) begin
               errors++;
               $display("FAIL out0_data got=%0d/%b/%b want=%0d/%b/%b", $signed(if0.out_data),
                        if0.out_start, if0.out_last, e0.d, e0.s, e0.l);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (res_n && if1.out_valid && if1.out_ready) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL out1_unexpected got=%0d", $signed(if1.out_data));
         end else begin
            e1 = q1.pop_front();
            if ($signed(if1.out_data) !== e1.d || if1.out_start !== e1.s || if1.out_last !== e1.l) begin
               errors++;
               $display("FAIL out1_data got=%0d/%b/%b want=%0d/%b/%b", $signed(if1.out_data),
                        if1.out_start, if1.out_last, e1.d, e1.s, e1.l);
            end
         end
      end
   end

   // Model: saturating 16-bit sums of rows[], then shift/ReLU/8-bit clamp.
   task automatic push_group(input int sel, input int sh, input bit relu);
      int tot[N];
      exp_t x;
      for (int n = 0; n < N; n++) begin
         tot[n] = 0;
         for (int r = 0; r < D; r++) begin
            tot[n] = tot[n] + rows[r][n];
            if (tot[n] > 32767)  tot[n] = 32767;
            if (tot[n] < -32768) tot[n] = -32768;
         end
      end
      for (int n = N - 1; n >= 0; n--) begin
         x.d = tot[n] >>> sh;
         if (relu && x.d < 0) x.d = 0;
         if (x.d > 127)  x.d = 127;
         if (x.d < -128) x.d = -128;
         x.s = (n == N - 1);
         x.l = (n == 0);
         if (sel == 0) q0.push_back(x); else q1.push_back(x);
      end
   endtask

   task automatic send_row(input int sel, input int r[N], input bit st);
      bit ok = 1'b0;
      int t = 0;
      for (int i = 0; i < N; i++) begin
         if (sel == 0) if0.in_data[i] = 8'(r[i]); else if1.in_data[i] = 8'(r[i]);
      end
      if (sel == 0) begin if0.in_valid = 1'b1; if0.in_start = st; end
      else          begin if1.in_valid = 1'b1; if1.in_start = st; end
      while (!ok && t < 300) begin
         @(negedge clk);
         ok = (sel == 0) ? if0.in_ready : if1.in_ready;
         t++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_row_timeout sel=%0d", sel);
      end
      @(posedge clk);
      #1;
      if (sel == 0) if0.in_valid = 1'b0; else if1.in_valid = 1'b0;
   endtask

   task automatic send_group(input int sel, input int sh, input bit relu);
      push_group(sel, sh, relu);
      for (int r = 0; r < D; r++) send_row(sel, rows[r], r == 0);
   endtask

   task automatic wait_empty(input int sel);
      int t = 0;
      while (((sel == 0) ? q0.size() : q1.size()) != 0 && t < 400) begin
         @(posedge clk);
         t++;
      end
      checks++;
      if (((sel == 0) ? q0.size() : q1.size()) != 0) begin
         errors++;
         $display("FAIL drain_timeout sel=%0d left=%0d want=0", sel, (sel == 0) ? q0.size() : q1.size());
      end
   endtask

   task automatic rand_rows();
      for (int r = 0; r < D; r++)
         for (int n = 0; n < N; n++) rows[r][n] = int'($urandom_range(0, 120)) - 60;
   endtask

   task automatic test_reset();
      res_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 6;
      if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", if0.out_valid); end
      if (if0.out_start !== 1'b0) begin errors++; $display("FAIL rst_out_start got=%b want=0", if0.out_start); end
      if (if0.out_last  !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b want=0", if0.out_last); end
      if (if0.out_data  !== 8'd0) begin errors++; $display("FAIL rst_out_data got=%0d want=0", if0.out_data); end
      if (if0.overflow  !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b want=0", if0.overflow); end
      if (if0.in_ready  !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", if0.in_ready); end
      res_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", if0.in_ready); end
   endtask

   task automatic test_basic();
      if0.out_ready = 1'b1;
      rows = '{'{1, 2, 3, 4}, '{10, 20, 30, 40}};
      send_group(0, 0, 0);
      checks += 2;
      if (if0.out_valid !== 1'b1 || $signed(if0.out_data) !== 44) begin
         errors++;
         $display("FAIL basic_latency got=%b/%0d want=1/44", if0.out_valid, $signed(if0.out_data));
      end
      if (if0.out_start !== 1'b1) begin errors++; $display("FAIL basic_start got=%b want=1", if0.out_start); end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL basic_stream k=%0d got=%b want=1", k, if0.out_valid); end
      end
      wait_empty(0);
      checks++;
      if (if0.overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got=%b want=0", if0.overflow); end
   endtask

   task automatic test_saturation();
      rows = '{'{100, 100, 100, 100}, '{100, 100, 100, 100}};
      send_group(0, 0, 0);
      wait_empty(0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (if0.overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got=%b want=1", if0.overflow); end
   endtask

   task automatic test_relu_shift();
      if1.out_ready = 1'b1;
      rows = '{'{-5, 6, -7, 8}, '{-5, 6, -7, 8}};
      send_group(1, 1, 1);
      wait_empty(1);
      checks++;
      if (if1.overflow !== 1'b0) begin errors++; $display("FAIL relu_overflow got=%b want=0", if1.overflow); end
   endtask

   task automatic test_back_to_back();
      if0.out_ready = 1'b0;
      rand_rows();
      send_group(0, 0, 0);
      rand_rows();
      send_group(0, 0, 0);
      checks += 2;
      if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b want=0", if0.in_ready); end
      if (if0.out_valid !== 1'b1 || if0.out_start !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drain_head got=%b/%b want=1/1", if0.out_valid, if0.out_start);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ($signed(if0.out_data) !== q0[0].d) begin
         errors++;
         $display("FAIL b2b_hold got=%0d want=%0d", $signed(if0.out_data), q0[0].d);
      end
      rand_rows();
      fork
         begin repeat (6) @(posedge clk); #2 if0.out_ready = 1'b1; end
         send_group(0, 0, 0);
      join
      wait_empty(0);
   endtask

   task automatic test_resync();
      if0.out_ready = 1'b1;
      one = '{9, 9, 9, 9};
      send_row(0, one, 1'b0);
      one = '{5, 5, 5, 5};
      send_row(0, one, 1'b1);
      rows = '{'{1, 2, 3, 4}, '{2, 2, 2, 2}};
      send_group(0, 0, 0);
      wait_empty(0);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL resync_extra got=%b want=0", if0.out_valid); end
   endtask

   task automatic test_reset_mid_drain();
      int t = 0;
      checks++;
      if (if0.overflow !== 1'b1) begin errors++; $display("FAIL sticky_overflow got=%b want=1", if0.overflow); end
      if0.out_ready = 1'b1;
      rand_rows();
      send_group(0, 0, 0);
      while (q0.size() > 2 && t < 50) begin @(posedge clk); t++; end
      #2 res_n = 1'b0;
      #1;
      checks += 2;
      if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b want=0", if0.out_valid); end
      if (if0.in_ready !== 1'b0)  begin errors++; $display("FAIL rst_mid_ready got=%b want=0", if0.in_ready); end
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      #1 res_n = 1'b1;
      @(posedge clk);
      #1;
      checks += 2;
      if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release got=%b want=1", if0.in_ready); end
      if (if0.overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow got=%b want=0", if0.overflow); end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale got=%b want=0", if0.out_valid); end
   endtask

   initial begin
      if0.in_valid = 1'b0; if0.in_start = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
      if1.in_valid = 1'b0; if1.in_start = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_saturation();
      test_relu_shift();
      test_back_to_back();
      test_resync();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
